// File: rtl/pc_sequencer.sv
// Fetch PC owner and instruction-bus request sequencer with a 1-entry skid buffer.
// Optional performance counters are built when PC_SEQ_PERF_EN is defined.
module pc_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ibus_ok,
  input  logic [31:0] ibus_data,
  input  logic [63:0] pred_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc,
  output logic        req_valid,
  output logic        out_valid,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] perf_wait_cyc,
  output logic [31:0] perf_redirects,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DROP = 2'd1;
  localparam logic [1:0] ST_BUF  = 2'd2;

  // Handshake: once req_valid=1 is presented with a pc, both hold until ibus_ok=1
  // completes that request; ibus_data is only meaningful in that completing cycle.
  logic [1:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pend_pc_q, pend_pc_d;
  logic [63:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;

  logic        req_valid_c;
  logic        out_valid_c;
  logic [63:0] out_pc_c;
  logic [31:0] out_instr_c;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    req_valid_c = 1'b0;
    out_valid_c = 1'b0;
    out_pc_c    = 64'd0;
    out_instr_c = 32'd0;
    case (state_q)
      ST_RUN: begin
        req_valid_c = 1'b1;
        if (ibus_ok) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else if (!stall) begin
            out_valid_c = 1'b1;
            out_pc_c    = pc_q;
            out_instr_c = ibus_data;
            pc_d        = pred_pc;
          end else begin
            buf_pc_d    = pc_q;
            buf_instr_d = ibus_data;
            pc_d        = pred_pc;
            state_d     = ST_BUF;
          end
        end else if (redirect_valid) begin
          // The request is already on the bus, so wait it out before redirecting.
          pend_pc_d = redirect_pc;
          state_d   = ST_DROP;
        end
      end
      ST_DROP: begin
        req_valid_c = 1'b1;
        if (ibus_ok) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
          state_d = ST_RUN;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_pc;
        end
      end
      ST_BUF: begin
        if (redirect_valid) begin
          buf_pc_d    = 64'd0;
          buf_instr_d = 32'd0;
          pc_d        = redirect_pc;
          state_d     = ST_RUN;
        end else begin
          out_valid_c = 1'b1;
          out_pc_c    = buf_pc_q;
          out_instr_c = buf_instr_q;
          if (!stall) state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      pend_pc_q   <= 64'd0;
      buf_pc_q    <= 64'd0;
      buf_instr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_pc_q   <= pend_pc_d;
      buf_pc_q    <= buf_pc_d;
      buf_instr_q <= buf_instr_d;
    end
  end

  // Outputs are forced quiet while reset is held so the async reset is visible at once.
  assign pc        = pc_q;
  assign req_valid = req_valid_c;
  assign out_valid = reset & out_valid_c;
  assign out_pc    = reset ? out_pc_c : 64'd0;
  assign out_instr = reset ? out_instr_c : 32'd0;
  assign dbg_state = state_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] wait_cyc_q, wait_cyc_d;
  logic [31:0] redirects_q, redirects_d;

  always_comb begin
    wait_cyc_d  = wait_cyc_q;
    redirects_d = redirects_q;
    if (req_valid_c && !ibus_ok && (wait_cyc_q != 32'hFFFF_FFFF)) wait_cyc_d = wait_cyc_q + 32'd1;
    if (redirect_valid && (redirects_q != 32'hFFFF_FFFF)) redirects_d = redirects_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cyc_q  <= 32'd0;
      redirects_q <= 32'd0;
    end else begin
      wait_cyc_q  <= wait_cyc_d;
      redirects_q <= redirects_d;
    end
  end

  assign perf_wait_cyc  = wait_cyc_q;
  assign perf_redirects = redirects_q;
`else
  assign perf_wait_cyc  = 32'd0;
  assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: streaming, skid buffer, redirects, DROP and async reset.
module tb_pc_sequencer;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk;
  logic        reset;
  logic        ibus_ok;
  logic [31:0] ibus_data;
  logic [63:0] pred_pc;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] pc;
  logic        req_valid;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] perf_wait_cyc;
  logic [31:0] perf_redirects;
  logic [1:0]  dbg_state;

  int vec_cnt;
  int err_cnt;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ibus_ok(ibus_ok), .ibus_data(ibus_data), .pred_pc(pred_pc),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc),
    .req_valid(req_valid), .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .perf_wait_cyc(perf_wait_cyc), .perf_redirects(perf_redirects), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ibus_ok        = 1'b0;
    ibus_data      = 32'd0;
    pred_pc        = 64'd0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic drive(input logic ok, input logic [31:0] data, input logic [63:0] pp,
                       input logic st, input logic rv, input logic [63:0] rp);
    ibus_ok = ok; ibus_data = data; pred_pc = pp; stall = st; redirect_valid = rv; redirect_pc = rp;
    #3;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    vec_cnt++; if (pc !== RST_PC) begin err_cnt++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
    vec_cnt++; if (req_valid !== 1'b1) begin err_cnt++; $display("FAIL reset_req_valid: got %b want 1", req_valid); end
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vec_cnt++; if (out_pc !== 64'd0) begin err_cnt++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    vec_cnt++; if (out_instr !== 32'd0) begin err_cnt++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
    vec_cnt++; if (perf_wait_cyc !== 32'd0 || perf_redirects !== 32'd0) begin err_cnt++;
      $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_wait_cyc, perf_redirects); end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [63:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc = RST_PC + 64'(4 * i);
      drive(1'b1, 32'hA000_0000 + 32'(i), exp_pc + 64'd4, 1'b0, 1'b0, 64'd0);
      vec_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL stream_out_valid[%0d]: got %b want 1", i, out_valid); end
      vec_cnt++; if (out_pc !== exp_pc) begin err_cnt++; $display("FAIL stream_out_pc[%0d]: got %h want %h", i, out_pc, exp_pc); end
      vec_cnt++; if (out_instr !== 32'hA000_0000 + 32'(i)) begin err_cnt++;
        $display("FAIL stream_out_instr[%0d]: got %h want %h", i, out_instr, 32'hA000_0000 + 32'(i)); end
      tick();
    end
  endtask

  task automatic test_stall_buf();
    do_reset();
    drive(1'b1, 32'h0000_0013, RST_PC + 64'd4, 1'b1, 1'b0, 64'd0);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL buf_fill_out_valid: got %b want 0", out_valid); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'hDEAD_BEEF, 64'd0, 1'b1, 1'b0, 64'd0);
      vec_cnt++; if (req_valid !== 1'b0) begin err_cnt++; $display("FAIL buf_req_valid[%0d]: got %b want 0", i, req_valid); end
      vec_cnt++; if (out_valid !== 1'b1 || out_pc !== RST_PC || out_instr !== 32'h0000_0013) begin err_cnt++;
        $display("FAIL buf_hold[%0d]: got v=%b pc=%h i=%h want v=1 pc=%h i=00000013", i, out_valid, out_pc, out_instr, RST_PC); end
      tick();
    end
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin err_cnt++;
      $display("FAIL buf_consume: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, RST_PC); end
    tick();
    drive(1'b1, 32'h0000_0093, RST_PC + 64'd8, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (req_valid !== 1'b1 || pc !== RST_PC + 64'd4) begin err_cnt++;
      $display("FAIL buf_resume_pc: got req=%b pc=%h want req=1 pc=%h", req_valid, pc, RST_PC + 64'd4); end
    vec_cnt++; if (out_valid !== 1'b1 || out_pc !== RST_PC + 64'd4 || out_instr !== 32'h0000_0093) begin err_cnt++;
      $display("FAIL buf_resume_out: got v=%b pc=%h i=%h want v=1 pc=80000004 i=00000093", out_valid, out_pc, out_instr); end
    tick();
  endtask

  task automatic test_redirect_drop();
    do_reset();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h8000_0100);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL drop_enter_out_valid: got %b want 0", out_valid); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 64'd0);
      vec_cnt++; if (pc !== RST_PC || req_valid !== 1'b1 || out_valid !== 1'b0) begin err_cnt++;
        $display("FAIL drop_hold[%0d]: got pc=%h req=%b v=%b want pc=%h req=1 v=0", i, pc, req_valid, out_valid, RST_PC); end
      tick();
    end
    drive(1'b1, 32'hBAD0_BAD0, 64'h8000_0004, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL drop_discard: got %b want 0", out_valid); end
    tick();
    drive(1'b1, 32'h1234_5678, 64'h8000_0104, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (pc !== 64'h8000_0100 || out_valid !== 1'b1 || out_pc !== 64'h8000_0100 || out_instr !== 32'h1234_5678) begin
      err_cnt++; $display("FAIL drop_resume: got pc=%h v=%b opc=%h i=%h want pc=80000100 v=1 opc=80000100 i=12345678",
                          pc, out_valid, out_pc, out_instr); end
`ifdef PC_SEQ_PERF_EN
    vec_cnt++; if (perf_wait_cyc !== 32'd5 || perf_redirects !== 32'd1) begin err_cnt++;
      $display("FAIL perf_counts: got %0d/%0d want 5/1", perf_wait_cyc, perf_redirects); end
`else
    vec_cnt++; if (perf_wait_cyc !== 32'd0 || perf_redirects !== 32'd0) begin err_cnt++;
      $display("FAIL perf_disabled: got %0d/%0d want 0/0", perf_wait_cyc, perf_redirects); end
`endif
    tick();
  endtask

  task automatic test_redirect_stall();
    do_reset();
    drive(1'b1, 32'h0000_0013, RST_PC + 64'd4, 1'b1, 1'b1, 64'h8000_0200);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rs_out_valid: got %b want 0", out_valid); end
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (pc !== 64'h8000_0200 || req_valid !== 1'b1 || out_valid !== 1'b0) begin err_cnt++;
      $display("FAIL rs_next: got pc=%h req=%b v=%b want pc=80000200 req=1 v=0", pc, req_valid, out_valid); end
    tick();
  endtask

  task automatic test_buf_redirect();
    do_reset();
    drive(1'b1, 32'h0000_0013, RST_PC + 64'd4, 1'b1, 1'b0, 64'd0);
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 64'h8000_0800);
    vec_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bufredir_out_valid: got %b want 0", out_valid); end
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (pc !== 64'h8000_0800 || req_valid !== 1'b1 || out_valid !== 1'b0) begin err_cnt++;
      $display("FAIL bufredir_next: got pc=%h req=%b v=%b want pc=80000800 req=1 v=0", pc, req_valid, out_valid); end
    tick();
  endtask

  task automatic test_double_redirect();
    do_reset();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h8000_0300);
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h8000_0400);
    tick();
    drive(1'b1, 32'hBAD0_0001, 64'h8000_0004, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (out_valid !== 1'b0 || pc !== RST_PC) begin err_cnt++;
      $display("FAIL dbl_discard: got v=%b pc=%h want v=0 pc=%h", out_valid, pc, RST_PC); end
    tick();
    // Redirect in the same cycle as the DROP completion wins over pend_pc.
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h8000_0440);
    vec_cnt++; if (pc !== 64'h8000_0400) begin err_cnt++; $display("FAIL dbl_resume: got %h want 80000400", pc); end
    tick();
    drive(1'b1, 32'd0, 64'd0, 1'b0, 1'b1, 64'h8000_0500);
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (pc !== 64'h8000_0500) begin err_cnt++; $display("FAIL drop_same_cycle_redirect: got %h want 80000500", pc); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 32'h0000_0001, RST_PC + 64'd4, 1'b0, 1'b0, 64'd0);
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b1, 64'h8000_0900);
    tick();
    drive(1'b0, 32'd0, 64'd0, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (pc !== RST_PC + 64'd4) begin err_cnt++; $display("FAIL ar_pre_pc: got %h want 80000004", pc); end
    reset = 1'b0;
    #1;
    vec_cnt++; if (pc !== RST_PC || out_valid !== 1'b0) begin err_cnt++;
      $display("FAIL ar_immediate: got pc=%h v=%b want pc=%h v=0", pc, out_valid, RST_PC); end
    vec_cnt++; if (perf_wait_cyc !== 32'd0 || perf_redirects !== 32'd0) begin err_cnt++;
      $display("FAIL ar_perf: got %0d/%0d want 0/0", perf_wait_cyc, perf_redirects); end
    tick();
    reset = 1'b1;
    drive(1'b1, 32'h0000_0077, RST_PC + 64'd4, 1'b0, 1'b0, 64'd0);
    vec_cnt++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin err_cnt++;
      $display("FAIL ar_no_drop_wait: got v=%b pc=%h want v=1 pc=%h", out_valid, out_pc, RST_PC); end
    tick();
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    idle_inputs();
    reset = 1'b1;
    #2;
    test_reset();
    test_stream();
    test_stall_buf();
    test_redirect_drop();
    test_redirect_stall();
    test_buf_redirect();
    test_double_redirect();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
